csr_bram_loader: RTL and testbench

Writer-side counterpart to the CSR traversal engine's BRAM read port. It accepts the compiled CSR/state-transition table as a stream of narrow words through a valid/ready handshake and packs them into full-width BRAM lines. Each completed line is written to consecutive BRAM addresses starting at 0. It runs before traversal, populating the block memory that the traversal engine later reads at `rd_address`/`rd_bus`.

---
 rtl/csr_bram_loader.sv | 149 ++++++++++++++
 tb/tb_csr_bram_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_bram_loader.sv
// csr_bram_loader: packs a narrow word stream into BRAM lines.
// Optional CSR_LOADER_CHECKSUM_EN adds a running word checksum.
module csr_bram_loader #(
  parameter int WORD_W = 32,
  parameter int LINE_W = 4096,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_lines,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_address,
  output logic [LINE_W-1:0] wr_bus,
  output logic              busy,
  output logic              done,
`ifdef CSR_LOADER_CHECKSUM_EN
  output logic [WORD_W-1:0] checksum,
`endif
  output logic [ADDR_W-1:0] lines_written
);

  localparam int WPL = LINE_W / WORD_W;
  localparam int IDX_W = (WPL > 1) ? $clog2(WPL) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WPL - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] nlines_q;
  logic [ADDR_W-1:0] line_idx_q;
  logic [ADDR_W-1:0] lines_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [IDX_W-1:0]  word_idx_q;
  logic [LINE_W-1:0] line_q;
  logic [LINE_W-1:0] line_nxt;
  logic [LINE_W-1:0] wr_bus_q;
  logic              go;
  logic              xfer;
  logic              last_word;
  logic              final_line;

  assign go = start && (state == IDLE || state == DONE);
  assign xfer = in_valid && in_ready;
  assign last_word = (word_idx_q == LAST);
  assign final_line = (lines_q + ADDR_W'(1)) == nlines_q;

  assign wr_address = wr_addr_q;
  assign wr_bus = wr_bus_q;
  assign lines_written = lines_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    in_ready = 1'b0;
    wr_en = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        if (start)
          state_nxt = (num_lines == '0) ? DONE : FILL;
      end
      (state == FILL): begin
        in_ready = 1'b1;
        busy = 1'b1;
        if (in_valid && last_word)
          state_nxt = WRITE;
      end
      (state == WRITE): begin
        wr_en = 1'b1;
        busy = 1'b1;
        state_nxt = final_line ? DONE : FILL;
      end
      (state == DONE): begin
        done = 1'b1;
        if (start)
          state_nxt = (num_lines == '0) ? DONE : FILL;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Line assembled with the current word dropped in its slot.
  always_comb begin
    line_nxt = line_q;
    line_nxt[word_idx_q*WORD_W +: WORD_W] = in_data;
  end

  // Word packing, line/address counters and write-port registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      nlines_q <= '0;
      line_idx_q <= '0;
      lines_q <= '0;
      wr_addr_q <= '0;
      word_idx_q <= '0;
      line_q <= '0;
      wr_bus_q <= '0;
    end else begin
      if (go) begin
        nlines_q <= num_lines;
        line_idx_q <= '0;
        lines_q <= '0;
        word_idx_q <= '0;
        line_q <= '0;
      end
      if (xfer) begin
        line_q <= line_nxt;
        if (last_word) begin
          word_idx_q <= '0;
          wr_bus_q <= line_nxt;
          wr_addr_q <= line_idx_q;
        end else begin
          word_idx_q <= word_idx_q + IDX_W'(1);
        end
      end
      if (state == WRITE) begin
        line_idx_q <= line_idx_q + ADDR_W'(1);
        lines_q <= lines_q + ADDR_W'(1);
      end
    end
  end

`ifdef CSR_LOADER_CHECKSUM_EN
  // Modular sum of every accepted word in the current load.
  always_ff @(posedge clk) begin
    if (reset)     checksum <= '0;
    else if (go)   checksum <= '0;
    else if (xfer) checksum <= checksum + in_data;
  end
`endif

endmodule

// File: tb/tb_csr_bram_loader.sv
// tb_csr_bram_loader: directed and random loads vs a packing model.
// Optional CSR_LOADER_CHECKSUM_EN also checks the checksum port.
module tb_csr_bram_loader;

  localparam int WORD_W = 32;
  localparam int LINE_W = 64;
  localparam int ADDR_W = 17;
  localparam int WPL = LINE_W / WORD_W;

  logic              tb_clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] num_lines;
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_address;
  logic [LINE_W-1:0] wr_bus;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] lines_written;
`ifdef CSR_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] checksum;
`endif

  csr_bram_loader #(
    .WORD_W(WORD_W),
    .LINE_W(LINE_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk(tb_clk),
    .reset(reset),
    .start(start),
    .num_lines(num_lines),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .wr_en(wr_en),
    .wr_address(wr_address),
    .wr_bus(wr_bus),
    .busy(busy),
    .done(done),
`ifdef CSR_LOADER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .lines_written(lines_written)
  );

  always #5 tb_clk = ~tb_clk;

  int checks = 0;
  int passes = 0;
  int fails = 0;
  int cyc = 0;
  int rdy_cnt = 0;
  logic [ADDR_W-1:0] wq_addr[$];
  logic [LINE_W-1:0] wq_data[$];

  // Record BRAM writes and ready cycles away from the active edge.
  always @(negedge tb_clk) begin
    if (wr_en) begin
      wq_addr.push_back(wr_address);
      wq_data.push_back(wr_bus);
    end
    if (in_ready) rdy_cnt++;
  end

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge tb_clk);
    #1;
    cyc++;
  endtask

  function automatic logic [LINE_W-1:0] pack(
      input logic [WORD_W-1:0] w[$], input int line);
    logic [LINE_W-1:0] l = '0;
    for (int k = 0; k < WPL; k++)
      l = l | (LINE_W'(w[line*WPL + k]) << (k*WORD_W));
    return l;
  endfunction

  // Start a load and feed words; wait for done if all words given.
  task automatic load(input int n,
                      input logic [WORD_W-1:0] w[$],
                      input int stall,
                      input bit chk_rdy,
                      input int inj,
                      output int fill_cyc);
    int g;
    wq_addr.delete();
    wq_data.delete();
    start = 1'b1;
    num_lines = ADDR_W'(n);
    tick();
    start = 1'b0;
    cyc = 0;
    for (int i = 0; i < w.size(); i++) begin
      if (i == inj) begin
        in_valid = 1'b0;
        start = 1'b1;
        num_lines = ADDR_W'(5);
        tick();
        start = 1'b0;
      end
      for (int s = 0; s < stall; s++) begin
        in_valid = 1'b0;
        in_data = $urandom;
        if (chk_rdy)
          check("stall_ready", 64'(in_ready),
                64'(!(s == 0 && i > 0 && i % WPL == 0)));
        tick();
      end
      in_valid = 1'b1;
      in_data = w[i];
      g = 0;
      while (!in_ready && g < 20) begin
        tick();
        g++;
      end
      if (g >= 20) check("ready_timeout", 64'(in_ready), 64'(1));
      tick();
    end
    in_valid = 1'b0;
    fill_cyc = 0;
    if (w.size() == n * WPL) begin
      g = 0;
      while (!done && g < 100) begin
        tick();
        g++;
      end
      check("done_wait", 64'(done), 64'(1));
      fill_cyc = cyc;
    end
  endtask

  // Compare recorded writes and final status against the packing model.
  task automatic verify(input int n, input logic [WORD_W-1:0] w[$]);
    logic [WORD_W-1:0] sum = '0;
    check("write_count", 64'(wq_addr.size()), 64'(n));
    for (int i = 0; i < n && i < wq_addr.size(); i++) begin
      check("wr_address", 64'(wq_addr[i]), 64'(i));
      check("wr_bus", 64'(wq_data[i]), 64'(pack(w, i)));
    end
    check("lines_written", 64'(lines_written), 64'(n));
    check("busy_at_done", 64'(busy), 64'(0));
    foreach (w[i]) sum = sum + w[i];
`ifdef CSR_LOADER_CHECKSUM_EN
    check("checksum", 64'(checksum), 64'(sum));
`else
    if (sum == '1) $display("note: all-ones word sum");
`endif
  endtask

  initial begin
    logic [WORD_W-1:0] basic[$];
    logic [WORD_W-1:0] part[$];
    logic [WORD_W-1:0] rw[$];
    int fc;
    int n;
    int st;

    basic = '{32'h11111111, 32'h22222222,
              32'h33333333, 32'h44444444};

    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom);
      num_lines = ADDR_W'($urandom);
      in_data = $urandom;
      in_valid = 1'($urandom);
      tick();
    end
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_wr_en", 64'(wr_en), 64'(0));
    check("rst_wr_address", 64'(wr_address), 64'(0));
    check("rst_wr_bus", 64'(wr_bus), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_lines", 64'(lines_written), 64'(0));
`ifdef CSR_LOADER_CHECKSUM_EN
    check("rst_checksum", 64'(checksum), 64'(0));
`endif
    reset = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    tick();

    load(2, basic, 0, 1'b0, -1, fc);
    check("basic_latency", 64'(fc), 64'(2 * (WPL + 1)));
    verify(2, basic);

    load(2, basic, 3, 1'b1, -1, fc);
    verify(2, basic);

    wq_addr.delete();
    wq_data.delete();
    rdy_cnt = 0;
    start = 1'b1;
    num_lines = '0;
    in_valid = 1'b1;
    in_data = $urandom;
    tick();
    start = 1'b0;
    check("zero_done", 64'(done), 64'(1));
    check("zero_busy", 64'(busy), 64'(0));
    for (int i = 0; i < 4; i++) tick();
    in_valid = 1'b0;
    check("zero_writes", 64'(wq_addr.size()), 64'(0));
    check("zero_ready", 64'(rdy_cnt), 64'(0));
    check("zero_lines", 64'(lines_written), 64'(0));

    part = '{32'h01010101, 32'h02020202, 32'h03030303};
    load(2, part, 0, 1'b0, -1, fc);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_writes", 64'(wq_addr.size()), 64'(1));
    if (wq_addr.size() > 0)
      check("abort_addr", 64'(wq_addr[0]), 64'(0));
    check("abort_lines", 64'(lines_written), 64'(0));
    part = '{32'hAAAAAAAA, 32'hBBBBBBBB};
    load(1, part, 0, 1'b0, -1, fc);
    verify(1, part);
    check("restart_bus", 64'(wr_bus), 64'hBBBBBBBBAAAAAAAA);

    load(2, basic, 0, 1'b0, 1, fc);
    verify(2, basic);
`ifdef CSR_LOADER_CHECKSUM_EN
    check("basic_checksum", 64'(checksum), 64'hAAAAAAAA);
`endif

    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 5);
      st = $urandom_range(0, 2);
      rw.delete();
      for (int i = 0; i < n * WPL; i++) rw.push_back($urandom);
      load(n, rw, st, 1'b1, -1, fc);
      verify(n, rw);
      if (st == 0)
        check("rand_latency", 64'(fc), 64'(n * (WPL + 1)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
